// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath sequencers.
//   - Default data width and feature-map dimensions.
//   - Sequencer state encoding for pool_sched.
//   - pooled_size(): number of 2x2 max-pool results for a w x h map.
package cnn_pkg;

  localparam int unsigned CnnDataW = 32;
  localparam int unsigned CnnMapW  = 26;
  localparam int unsigned CnnMapH  = 26;
  localparam int unsigned CnnNumCh = 3;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StFeed,
    StDrain,
    StDone
  } pool_state_e;

  function automatic int unsigned pooled_size(input int unsigned w, input int unsigned h);
    return (w / 2) * (h / 2);
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Raster read-address generator for pool_sched.
// Holds the channel/row/col counters and forms ch*W*H + row*W + col.
// Ports:
//   clk, clr      clock, asynchronous active-high reset
//   init          clear channel, row and col (new run)
//   feed          sequencer is in its feed phase
//   hold          suspend read issue while feeding
//   next_ch       advance to the next channel
//   rd_en         read strobe issued this cycle
//   rd_addr       feature-map read address
//   last          this cycle issues the final pixel of the channel
//   last_ch       current channel is the final one
//   ch            current channel index
module pool_addr_gen
  import cnn_pkg::*;
#(
  parameter int unsigned W     = CnnMapW,
  parameter int unsigned H     = CnnMapH,
  parameter int unsigned N_CH  = CnnNumCh,
  parameter int unsigned FM_AW = $clog2(N_CH * W * H),
  parameter int unsigned CH_W  = $clog2(N_CH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             init,
  input  logic             feed,
  input  logic             hold,
  input  logic             next_ch,
  output logic             rd_en,
  output logic [FM_AW-1:0] rd_addr,
  output logic             last,
  output logic             last_ch,
  output logic [CH_W-1:0]  ch
);

  localparam int unsigned ColW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned RowW = (H > 1) ? $clog2(H) : 1;

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            col_end, row_end;

  assign rd_en   = feed & ~hold;
  assign col_end = (col_q == ColW'(W - 1));
  assign row_end = (row_q == RowW'(H - 1));
  assign last    = rd_en & col_end & row_end;
  assign last_ch = (ch_q == CH_W'(N_CH - 1));
  assign ch      = ch_q;

  // Each term is widened to FM_AW before multiplying so the products never truncate.
  assign rd_addr = FM_AW'(ch_q) * FM_AW'(W * H)
                 + FM_AW'(row_q) * FM_AW'(W)
                 + FM_AW'(col_q);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ch_d  = ch_q;
    if (init) begin
      col_d = '0;
      row_d = '0;
      ch_d  = '0;
    end else begin
      if (rd_en) begin
        if (col_end) begin
          col_d = '0;
          // Row wraps after the final pixel so the next channel starts at (0,0).
          row_d = row_end ? '0 : row_q + RowW'(1);
        end else begin
          col_d = col_q + ColW'(1);
        end
      end
      if (next_ch) begin
        ch_d = ch_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      ch_q  <= ch_d;
    end
  end

endmodule

// File: rtl/pool_sched.sv
// Sequencer for the 2x2 max-pool + ReLU stage.
// Streams N_CH feature maps from the conv-output RAM into pool_relu one pixel
// per clock, clears the pool before each channel, and writes pooled results
// to the pooled-map RAM at a running address.
// Ports:
//   clk, clr                     clock, asynchronous active-high reset
//   start                        run request (only honoured when idle)
//   hold                         stall read issue while feeding
//   busy, done                   run in progress / one-cycle completion pulse
//   ch_idx                       current channel
//   fm_rd_en/addr/data           feature-map RAM read port (1-cycle latency)
//   pool_clr                     synchronous clear to pool_relu
//   pool_in_valid/data           pixel stream into pool_relu
//   pool_out_valid/data          pooled stream from pool_relu
//   out_wr_en/addr/data          pooled-map RAM write port
module pool_sched
  import cnn_pkg::*;
#(
  parameter int unsigned D_W    = CnnDataW,
  parameter int unsigned W      = CnnMapW,
  parameter int unsigned H      = CnnMapH,
  parameter int unsigned N_CH   = CnnNumCh,
  parameter int unsigned FM_AW  = $clog2(N_CH * W * H),
  parameter int unsigned OUT_AW = $clog2(N_CH * (W / 2) * (H / 2))
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     hold,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N_CH):0]    ch_idx,
  output logic                     fm_rd_en,
  output logic [FM_AW-1:0]         fm_rd_addr,
  input  logic [D_W-1:0]           fm_rd_data,
  output logic                     pool_clr,
  output logic                     pool_in_valid,
  output logic [D_W-1:0]           pool_in_data,
  input  logic                     pool_out_valid,
  input  logic [D_W-1:0]           pool_out_data,
  output logic                     out_wr_en,
  output logic [OUT_AW-1:0]        out_wr_addr,
  output logic [D_W-1:0]           out_wr_data
);

  localparam int unsigned ChW   = $clog2(N_CH) + 1;
  localparam int unsigned PoolN = pooled_size(W, H);
  localparam int unsigned CntW  = $clog2(PoolN + 1);

  if ((W % 2) != 0) begin : g_w_odd
    $error("pool_sched: W must be even");
  end
  if ((H % 2) != 0) begin : g_h_odd
    $error("pool_sched: H must be even");
  end

  pool_state_e       state_q, state_d;
  logic [OUT_AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0]   ch_cnt_q, ch_cnt_d;
  logic              in_valid_q;

  logic              feed, init, next_ch, last, last_ch, drained;

  assign feed    = (state_q == StFeed);
  assign drained = (ch_cnt_q == CntW'(PoolN));

  pool_addr_gen #(
    .W     (W),
    .H     (H),
    .N_CH  (N_CH),
    .FM_AW (FM_AW),
    .CH_W  (ChW)
  ) u_addr_gen (
    .clk     (clk),
    .clr     (clr),
    .init    (init),
    .feed    (feed),
    .hold    (hold),
    .next_ch (next_ch),
    .rd_en   (fm_rd_en),
    .rd_addr (fm_rd_addr),
    .last    (last),
    .last_ch (last_ch),
    .ch      (ch_idx)
  );

  // Pool results only land while a channel is being processed.
  assign out_wr_en     = pool_out_valid & ((state_q == StFeed) | (state_q == StDrain));
  assign out_wr_addr   = wr_cnt_q;
  assign out_wr_data   = pool_out_data;
  assign pool_in_valid = in_valid_q;
  assign pool_in_data  = fm_rd_data;
  assign busy          = (state_q != StIdle);
  assign pool_clr      = (state_q == StClr);
  assign done          = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    init    = 1'b0;
    next_ch = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          init    = 1'b1;
          state_d = StClr;
        end
      end
      StClr: begin
        state_d = StFeed;
      end
      StFeed: begin
        if (last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drained) begin
          if (last_ch) begin
            state_d = StDone;
          end else begin
            next_ch = 1'b1;
            state_d = StClr;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    ch_cnt_d = ch_cnt_q;
    if (init) begin
      wr_cnt_d = '0;
    end else if (out_wr_en) begin
      wr_cnt_d = wr_cnt_q + OUT_AW'(1);
    end
    if (state_q == StClr) begin
      ch_cnt_d = '0;
    end else if (out_wr_en) begin
      ch_cnt_d = ch_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StIdle;
      wr_cnt_q   <= '0;
      ch_cnt_q   <= '0;
      in_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      in_valid_q <= fm_rd_en;
    end
  end

endmodule

// File: tb/tb_pool_sched.sv
module tb_pool_sched;

  localparam int DW    = 32;
  localparam int MW    = 26;
  localparam int MH    = 26;
  localparam int NCH   = 3;
  localparam int FMAW  = 11;
  localparam int OUTAW = 9;
  localparam int PerCh = (MW / 2) * (MH / 2);
  localparam int Total = NCH * PerCh;
  localparam int ChPix = MW * MH;
  localparam int MinLat = NCH * (1 + ChPix + 2 + 1) + 1;

  logic               clk;
  logic               clr;
  logic               start;
  logic               hold;
  logic               busy;
  logic               done;
  logic [2:0]         ch_idx;
  logic               fm_rd_en;
  logic [FMAW-1:0]    fm_rd_addr;
  logic [DW-1:0]      fm_rd_data;
  logic               pool_clr;
  logic               pool_in_valid;
  logic [DW-1:0]      pool_in_data;
  logic               pool_out_valid;
  logic [DW-1:0]      pool_out_data;
  logic               out_wr_en;
  logic [OUTAW-1:0]   out_wr_addr;
  logic [DW-1:0]      out_wr_data;

  pool_sched #(
    .D_W    (DW),
    .W      (MW),
    .H      (MH),
    .N_CH   (NCH),
    .FM_AW  (FMAW),
    .OUT_AW (OUTAW)
  ) dut (
    .clk            (clk),
    .clr            (clr),
    .start          (start),
    .hold           (hold),
    .busy           (busy),
    .done           (done),
    .ch_idx         (ch_idx),
    .fm_rd_en       (fm_rd_en),
    .fm_rd_addr     (fm_rd_addr),
    .fm_rd_data     (fm_rd_data),
    .pool_clr       (pool_clr),
    .pool_in_valid  (pool_in_valid),
    .pool_in_data   (pool_in_data),
    .pool_out_valid (pool_out_valid),
    .pool_out_data  (pool_out_data),
    .out_wr_en      (out_wr_en),
    .out_wr_addr    (out_wr_addr),
    .out_wr_data    (out_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Feature-map contents: ramp, or strictly negative ramp.
  bit data_neg = 1'b0;

  function automatic int pix(input int a);
    return data_neg ? -(a + 1) : a;
  endfunction

  function automatic int relu_max4(input int a0, input int a1, input int a2, input int a3);
    int m;
    m = a0;
    if (a1 > m) m = a1;
    if (a2 > m) m = a2;
    if (a3 > m) m = a3;
    return (m < 0) ? 0 : m;
  endfunction

  // Expected k-th pooled write, derived from map geometry.
  function automatic int exp_val(input int k);
    int c, r, pr, pc, base;
    c    = k / PerCh;
    r    = k % PerCh;
    pr   = r / (MW / 2);
    pc   = r % (MW / 2);
    base = c * ChPix + 2 * pr * MW + 2 * pc;
    return relu_max4(pix(base), pix(base + 1), pix(base + MW), pix(base + MW + 1));
  endfunction

  // Feature-map RAM: one-cycle read latency.
  int addr_q;
  always @(posedge clk) begin
    if (fm_rd_en) begin
      fm_rd_data <= pix(int'(fm_rd_addr));
      addr_q     <= int'(fm_rd_addr);
    end
  end

  // pool_relu model: registered output after the bottom-right pixel of each window.
  int       pix_cnt;
  logic     pv_q;
  int       pd_q;
  bit       force_pov = 1'b0;
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      pix_cnt <= 0;
      pv_q    <= 1'b0;
      pd_q    <= 0;
    end else begin
      pv_q <= 1'b0;
      if (pool_clr) begin
        pix_cnt <= 0;
      end else if (pool_in_valid) begin
        pix_cnt <= pix_cnt + 1;
        if (((pix_cnt / MW) % 2 == 1) && ((pix_cnt % MW) % 2 == 1)) begin
          pv_q <= 1'b1;
          pd_q <= relu_max4(pix(addr_q - MW - 1), pix(addr_q - MW), pix(addr_q - 1),
                            pix(addr_q));
        end
      end
    end
  end
  assign pool_out_valid = pv_q | force_pov;
  assign pool_out_data  = pv_q ? pd_q : 32'h1234_5678;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor / write scoreboard.
  bit mon_en = 1'b0;
  int wr_seen, clr_seen, rd_seen, done_seen, done_cyc, start_cyc;
  bit want_first;
  int first_addr[NCH];
  int wr_log[Total];

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_wr_en) begin
        check("wr_addr", longint'(out_wr_addr), wr_seen);
        check("wr_data", longint'($signed(out_wr_data)), exp_val(wr_seen));
        if (wr_seen < Total) wr_log[wr_seen] = int'($signed(out_wr_data));
        wr_seen++;
      end
      if (pool_clr) begin
        clr_seen++;
        want_first = 1'b1;
      end
      if (fm_rd_en) begin
        rd_seen++;
        if (want_first && clr_seen >= 1 && clr_seen <= NCH) begin
          first_addr[clr_seen-1] = int'(fm_rd_addr);
        end
        want_first = 1'b0;
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_run(input bit neg);
    data_neg   = neg;
    wr_seen    = 0;
    clr_seen   = 0;
    rd_seen    = 0;
    done_seen  = 0;
    want_first = 1'b0;
    for (int i = 0; i < NCH; i++) first_addr[i] = -1;
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int hold_pct, input bit poke);
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
      hold = ($urandom_range(99) < hold_pct);
      if (poke) start = (n % 50 == 7);
    end
    hold  = 1'b0;
    start = 1'b0;
    check("done_timeout", longint'(n < 5000), 1);
  endtask

  task automatic finish_run(input bit chk_lat);
    repeat (6) @(negedge clk);
    check("busy_after", longint'(busy), 0);
    check("wr_count", wr_seen, Total);
    check("clr_pulses", clr_seen, NCH);
    check("rd_count", rd_seen, NCH * ChPix);
    check("done_pulses", done_seen, 1);
    for (int c = 0; c < NCH; c++) check("first_rd_addr", first_addr[c], c * ChPix);
    if (chk_lat) check("latency", done_cyc - start_cyc, MinLat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_rd_en"}, longint'(fm_rd_en), 0);
    check({tag, "_pool_clr"}, longint'(pool_clr), 0);
    check({tag, "_in_valid"}, longint'(pool_in_valid), 0);
    check({tag, "_rd_addr"}, longint'(fm_rd_addr), 0);
    check({tag, "_wr_addr"}, longint'(out_wr_addr), 0);
    check({tag, "_ch_idx"}, longint'(ch_idx), 0);
    check({tag, "_wr_en"}, longint'(out_wr_en), 0);
  endtask

  initial begin
    int n;
    clr   = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    clr = 1'b0;

    // Pool output in IDLE must never write.
    force_pov = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_wr_en", longint'(out_wr_en), 0);
    end
    check("idle_wr_addr", longint'(out_wr_addr), 0);
    force_pov = 1'b0;
    mon_en    = 1'b1;

    // Ramp data, no stall.
    start_run(1'b0);
    wait_done(0, 1'b0);
    finish_run(1'b1);
    check("wr0_data", wr_log[0], 27);
    check("wr1_data", wr_log[1], 29);
    check("wr13_data", wr_log[13], 79);
    check("wr169_data", wr_log[169], 703);
    check("wr506_data", wr_log[506], 2027);

    // Negative data, random stalls, extra start pulses while busy.
    start_run(1'b1);
    wait_done(30, 1'b1);
    finish_run(1'b0);
    check("neg_wr0_data", wr_log[0], 0);
    check("neg_wr506_data", wr_log[506], 0);

    // Asynchronous reset in the middle of channel 1.
    start_run(1'b0);
    n = 0;
    while (ch_idx != 3'd1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reach_ch1", longint'(n < 3000), 1);
    repeat (50) @(negedge clk);
    check("mid_feed_rd_en", longint'(fm_rd_en), 1);
    #2;
    clr = 1'b1;
    #1;
    check_reset_outputs("async_clr");
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    start_run(1'b0);
    wait_done(0, 1'b0);
    finish_run(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
